gpu_texcache_filler: RTL and testbench

Refill engine for the GPU dual-port direct-mapped texture cache. It watches the cache's two miss outputs (A, B) and arbitrates between them. For each missed line it issues one burst read to the VRAM memory port. It then writes the returned 64-bit words back into the cache through the cache's spy/write port. It sits between the cache and the GPU memory arbiter.

---
 rtl/gpu_texcache_pkg.sv | 20 ++
 rtl/gpu_texcache_filler_miss_arb.sv | 102 ++++++++++
 rtl/gpu_texcache_filler.sv | 137 +++++++++++++
 tb/tb_gpu_texcache_filler.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_texcache_pkg.sv
// Shared types and helpers for the texture-cache refill engine.
// Lookup addresses count 16-bit words; cache/VRAM addresses count 64-bit words.
package gpu_texcache_pkg;

    localparam int WORD_ADR_W = 17;
    localparam int LOOK_ADR_W = 19;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2,
        COOL = 2'd3
    } fillState_t;

    // Four 16-bit lookup words share one 64-bit cache word.
    function automatic logic [WORD_ADR_W-1:0] lineOf(input logic [LOOK_ADR_W-1:0] adr);
        return adr[LOOK_ADR_W-1:2];
    endfunction

endpackage

// File: rtl/gpu_texcache_filler_miss_arb.sv
// Pending-miss latches for cache ports A/B, base comparison and round-robin grant.
// Grants are only meaningful in a sample cycle (IDLE or end of cool-down).
module texcache_miss_arb
    import gpu_texcache_pkg::*;
#(
    parameter int BURST_LEN = 4
) (
    input  logic        i_clk,
    input  logic        i_nrst,
    input  logic        isMissA,
    input  logic [16:0] lineA,
    input  logic        isMissB,
    input  logic [16:0] lineB,
    input  logic        sample,
    input  logic        watch,
    input  logic        launch,
    input  logic        clear,
    input  logic [16:0] curBase,
    output logic        anyReq,
    output logic [16:0] grantBase
);

    localparam logic [16:0] LOW_MASK = 17'(BURST_LEN - 1);

    logic        pendA, pendB;
    logic        gntA, gntB;
    logic        preferB;
    logic [16:0] baseA, baseB;
    logic [16:0] newBaseA, newBaseB;
    logic [16:0] effBaseA, effBaseB;
    logic        effA, effB;
    logic        grantA, grantB, tie;

    assign newBaseA = lineA & ~LOW_MASK;
    assign newBaseB = lineB & ~LOW_MASK;

    // A latched pend keeps its original base even if the port misses again.
    assign effA     = pendA | (sample & isMissA);
    assign effB     = pendB | (sample & isMissB);
    assign effBaseA = pendA ? baseA : newBaseA;
    assign effBaseB = pendB ? baseB : newBaseB;
    assign anyReq   = effA | effB;

    always_comb begin
        grantA = 1'b0;
        grantB = 1'b0;
        tie    = 1'b0;
        if (effA && effB) begin
            if (effBaseA == effBaseB) begin
                grantA = 1'b1;
                grantB = 1'b1;
            end else begin
                tie    = 1'b1;
                grantA = !preferB;
                grantB = preferB;
            end
        end else begin
            grantA = effA;
            grantB = effB;
        end
        grantBase = grantA ? effBaseA : effBaseB;
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            pendA   <= 1'b0;
            pendB   <= 1'b0;
            baseA   <= '0;
            baseB   <= '0;
            gntA    <= 1'b0;
            gntB    <= 1'b0;
            preferB <= 1'b0;
        end else begin
            if (sample) begin
                pendA <= effA;
                pendB <= effB;
                baseA <= effBaseA;
                baseB <= effBaseB;
            end else if (watch) begin
                // A miss on the line being fetched is already covered by this burst.
                if (!gntA && isMissA && !pendA && (newBaseA != curBase)) begin
                    pendA <= 1'b1;
                    baseA <= newBaseA;
                end
                if (!gntB && isMissB && !pendB && (newBaseB != curBase)) begin
                    pendB <= 1'b1;
                    baseB <= newBaseB;
                end
            end
            if (launch) begin
                gntA <= grantA;
                gntB <= grantB;
                if (tie) preferB <= grantA;
            end
            if (clear) begin
                if (gntA) pendA <= 1'b0;
                if (gntB) pendB <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/gpu_texcache_filler.sv
// Texture-cache refill engine: one aligned VRAM burst per missed line, beats
// written back through the cache write port, then a short miss-ignore cool-down.
module gpu_texcache_filler
    import gpu_texcache_pkg::*;
#(
    parameter int BURST_LEN = 4,
    parameter int COOLDOWN  = 2
) (
    input  logic        i_clk,
    input  logic        i_nrst,
    input  logic        i_isMissA,
    input  logic [18:0] i_adressLookA,
    input  logic        i_isMissB,
    input  logic [18:0] i_adressLookB,
    output logic        o_memRequ,
    output logic [16:0] o_memAdr,
    input  logic        i_memAck,
    input  logic        i_memValid,
    input  logic [63:0] i_memData,
    output logic        o_write,
    output logic [16:0] o_adressOut,
    output logic [63:0] o_dataOut,
    output logic        o_busy
);

    localparam int          BW       = $clog2(BURST_LEN + 1);
    localparam int          CW       = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
    localparam logic [16:0] LOW_MASK = 17'(BURST_LEN - 1);

    fillState_t  state, nextState;
    logic [16:0] curBase;
    logic [BW-1:0] beatCnt;
    logic [CW-1:0] coolCnt;
    logic        sample, launch, clear, watch;
    logic        anyReq;
    logic [16:0] grantBase;
    logic        beatTake;
    logic        coolDone;
    logic [16:0] beatAdr;

    texcache_miss_arb #(.BURST_LEN(BURST_LEN)) u_arb (
        .i_clk     (i_clk),
        .i_nrst    (i_nrst),
        .isMissA   (i_isMissA),
        .lineA     (lineOf(i_adressLookA)),
        .isMissB   (i_isMissB),
        .lineB     (lineOf(i_adressLookB)),
        .sample    (sample),
        .watch     (watch),
        .launch    (launch),
        .clear     (clear),
        .curBase   (curBase),
        .anyReq    (anyReq),
        .grantBase (grantBase)
    );

    // Request handshake: o_memRequ/o_memAdr hold from REQ entry until i_memAck is
    // sampled high; then every i_memValid cycle in DATA is one beat (no backpressure).
    assign watch    = (state == REQ) || (state == DATA);
    assign beatTake = (state == DATA) && i_memValid;
    assign coolDone = (coolCnt == CW'(COOLDOWN));

    // Only the in-line offset advances, so a burst never carries into the next line.
    assign beatAdr = (curBase & ~LOW_MASK) | ((curBase + 17'(beatCnt)) & LOW_MASK);

    always_comb begin
        nextState = state;
        sample    = 1'b0;
        launch    = 1'b0;
        clear     = 1'b0;
        unique case (state)
            IDLE: begin
                sample = 1'b1;
                if (anyReq) begin
                    nextState = REQ;
                    launch    = 1'b1;
                end
            end
            REQ: begin
                if (i_memAck) begin
                    nextState = DATA;
                    clear     = 1'b1;
                end
            end
            DATA: begin
                if (beatTake && (beatCnt == BW'(BURST_LEN - 1))) nextState = COOL;
            end
            COOL: begin
                if (coolDone) begin
                    sample = 1'b1;
                    if (anyReq) begin
                        nextState = REQ;
                        launch    = 1'b1;
                    end else begin
                        nextState = IDLE;
                    end
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state       <= IDLE;
            curBase     <= '0;
            beatCnt     <= '0;
            coolCnt     <= '0;
            o_write     <= 1'b0;
            o_adressOut <= '0;
            o_dataOut   <= '0;
        end else begin
            state   <= nextState;
            o_write <= beatTake;
            if (launch) curBase <= grantBase;
            if (clear) begin
                beatCnt <= '0;
            end else if (beatTake) begin
                beatCnt <= beatCnt + BW'(1);
            end
            if ((state == COOL) && !coolDone) begin
                coolCnt <= coolCnt + CW'(1);
            end else begin
                coolCnt <= '0;
            end
            if (beatTake) begin
                o_adressOut <= beatAdr;
                o_dataOut   <= i_memData;
            end
        end
    end

    assign o_memRequ = (state == REQ);
    assign o_memAdr  = curBase;
    assign o_busy    = (state != IDLE);

endmodule

// File: tb/tb_gpu_texcache_filler.sv
// Directed bench for gpu_texcache_filler: a VRAM responder, an expected-request
// and expected-write scoreboard checked every cycle, and literal spot checks.
module tb_gpu_texcache_filler;

    localparam int BL = 4;
    localparam int CD = 2;

    logic        clk;
    logic        nrst;
    logic        missA, missB;
    logic [18:0] adrA, adrB;
    logic        memRequ;
    logic [16:0] memAdr;
    logic        memAck, memValid;
    logic [63:0] memData;
    logic        write;
    logic [16:0] adressOut;
    logic [63:0] dataOut;
    logic        busy;

    logic        beatDrv;
    logic [80:0] exp_q[$];
    logic [16:0] req_q[$];
    int          passCnt;
    int          checkCnt;

    gpu_texcache_filler #(.BURST_LEN(BL), .COOLDOWN(CD)) dut (
        .i_clk         (clk),
        .i_nrst        (nrst),
        .i_isMissA     (missA),
        .i_adressLookA (adrA),
        .i_isMissB     (missB),
        .i_adressLookB (adrB),
        .o_memRequ     (memRequ),
        .o_memAdr      (memAdr),
        .i_memAck      (memAck),
        .i_memValid    (memValid),
        .i_memData     (memData),
        .o_write       (write),
        .o_adressOut   (adressOut),
        .o_dataOut     (dataOut),
        .o_busy        (busy)
    );

    // clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passCnt, checkCnt);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] want);
        checkCnt++;
        if (act === want) passCnt++;
        else $display("FAIL %s: got %0h, want %0h", name, act, want);
    endtask

    // memory-side driver: wait for the request, optionally stall the ack, send beats
    task automatic serve(input logic [16:0] base, input int stall, input int gap, input int nBeats);
        int t;
        t = 0;
        while (!memRequ && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (!memRequ) begin
            checkCnt++;
            $display("FAIL request timeout: no request seen for base %0h", base);
            return;
        end
        repeat (stall) @(negedge clk);
        memAck = 1'b1;
        @(negedge clk);
        memAck = 1'b0;
        for (int i = 0; i < nBeats; i++) begin
            repeat (gap) @(negedge clk);
            memValid = 1'b1;
            memData  = {$urandom, $urandom};
            beatDrv  = 1'b1;
            exp_q.push_back({base + 17'(i), memData});
            @(negedge clk);
            memValid = 1'b0;
            beatDrv  = 1'b0;
        end
    endtask

    task automatic waitIdle();
        int t;
        t = 0;
        while (busy && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("return to idle", busy, 1'b0);
    endtask

    // scoreboard: per-cycle write and request checks against the queues
    initial begin : compare_proc
        logic        wantW, ackEdge, prevReq;
        logic [16:0] prevAdr, expAdr;
        logic [80:0] expW;
        prevReq = 1'b0;
        prevAdr = '0;
        forever begin
            @(posedge clk);
            wantW   = beatDrv;
            ackEdge = memAck;
            @(negedge clk);
            if (nrst) begin
                if (wantW) begin
                    if (exp_q.size() == 0) begin
                        checkCnt++;
                        $display("FAIL write model: beat driven but nothing queued");
                    end else begin
                        expW = exp_q.pop_front();
                        check("write beat", {write, adressOut, dataOut}, {1'b1, expW});
                    end
                end else begin
                    check("write idle", write, 1'b0);
                end
                if (memRequ && !prevReq) begin
                    checkCnt++;
                    if (req_q.size() == 0) begin
                        $display("FAIL unexpected request: got addr %0h, want none", memAdr);
                    end else begin
                        expAdr = req_q.pop_front();
                        if (memAdr === expAdr) passCnt++;
                        else $display("FAIL request addr: got %0h, want %0h", memAdr, expAdr);
                    end
                end
                if (prevReq && !ackEdge) check("request hold", {memRequ, memAdr}, {1'b1, prevAdr});
                if (prevReq && ackEdge)  check("request drop", memRequ, 1'b0);
            end
            prevReq = memRequ && nrst;
            prevAdr = memAdr;
        end
    end

    initial begin
        passCnt  = 0;
        checkCnt = 0;
        nrst     = 1'b0;
        missA    = 1'b0;
        missB    = 1'b0;
        adrA     = '0;
        adrB     = '0;
        memAck   = 1'b0;
        memValid = 1'b0;
        memData  = '0;
        beatDrv  = 1'b0;

        repeat (3) @(negedge clk);
        check("reset memRequ", memRequ, 1'b0);
        check("reset memAdr", memAdr, 17'h0);
        check("reset write", write, 1'b0);
        check("reset adressOut", adressOut, 17'h0);
        check("reset dataOut", dataOut, 64'h0);
        check("reset busy", busy, 1'b0);
        nrst = 1'b1;
        repeat (2) @(negedge clk);

        // single miss on A
        missA = 1'b1;
        adrA  = 19'h00010;
        req_q.push_back(17'h00004);
        @(negedge clk);
        check("miss to request latency", memRequ, 1'b1);
        check("single miss base", memAdr, 17'h00004);
        missA = 1'b0;
        serve(17'h00004, 0, 0, BL);
        check("last write address", {write, adressOut}, {1'b1, 17'h00007});
        for (int i = 0; i < CD; i++) begin
            @(negedge clk);
            check("busy during cool-down", busy, 1'b1);
        end
        @(negedge clk);
        check("busy drop after cool-down", busy, 1'b0);
        repeat (2) @(negedge clk);

        // same line on both ports: one fetch
        missA = 1'b1;
        adrA  = 19'h00040;
        missB = 1'b1;
        adrB  = 19'h00044;
        req_q.push_back(17'h00010);
        serve(17'h00010, 0, 0, BL);
        missA = 1'b0;
        missB = 1'b0;
        repeat (CD + 6) @(negedge clk);
        check("shared line single request", req_q.size(), 0);
        waitIdle();

        // different lines simultaneously, then round robin on the next tie
        missA = 1'b1;
        adrA  = 19'h00000;
        missB = 1'b1;
        adrB  = 19'h10000;
        req_q.push_back(17'h00000);
        req_q.push_back(17'h04000);
        serve(17'h00000, 1, 0, BL);
        missA = 1'b0;
        serve(17'h04000, 0, 1, BL);
        missB = 1'b0;
        waitIdle();
        missA = 1'b1;
        adrA  = 19'h00100;
        missB = 1'b1;
        adrB  = 19'h00200;
        req_q.push_back(17'h00080);
        req_q.push_back(17'h00040);
        serve(17'h00080, 0, 0, BL);
        missB = 1'b0;
        serve(17'h00040, 2, 0, BL);
        missA = 1'b0;
        waitIdle();

        // other-port miss while busy is latched and served afterwards
        missA = 1'b1;
        adrA  = 19'h00400;
        req_q.push_back(17'h00100);
        req_q.push_back(17'h00200);
        @(negedge clk);
        missB = 1'b1;
        adrB  = 19'h00804;
        @(negedge clk);
        missB = 1'b0;
        serve(17'h00100, 1, 0, BL);
        missA = 1'b0;
        serve(17'h00200, 0, 0, BL);
        waitIdle();

        // ack stall with stray valids before the ack
        missA = 1'b1;
        adrA  = 19'h12345;
        req_q.push_back(17'h048D0);
        @(negedge clk);
        missA = 1'b0;
        for (int i = 0; i < 10; i++) begin
            memValid = (i % 3 == 0);
            @(negedge clk);
            check("stall request", {memRequ, memAdr, write}, {1'b1, 17'h048D0, 1'b0});
        end
        memValid = 1'b0;
        serve(17'h048D0, 0, 1, BL);
        waitIdle();

        // sticky miss held into cool-down at the top line of the address space
        missA = 1'b1;
        adrA  = 19'h7FFF3;
        req_q.push_back(17'h1FFFC);
        serve(17'h1FFFC, 0, 0, BL);
        check("top line last write", adressOut, 17'h1FFFF);
        @(negedge clk);
        @(negedge clk);
        missA = 1'b0;
        repeat (CD + 6) @(negedge clk);
        check("no duplicate request", req_q.size(), 0);
        waitIdle();
        missA = 1'b1;
        req_q.push_back(17'h1FFFC);
        serve(17'h1FFFC, 0, 0, BL);
        missA = 1'b0;
        waitIdle();

        // asynchronous reset after two beats
        missA = 1'b1;
        adrA  = 19'h00020;
        req_q.push_back(17'h00008);
        @(negedge clk);
        missA = 1'b0;
        serve(17'h00008, 0, 0, 2);
        #2;
        nrst = 1'b0;
        #1;
        check("async reset memRequ", memRequ, 1'b0);
        check("async reset memAdr", memAdr, 17'h0);
        check("async reset write", write, 1'b0);
        check("async reset adressOut", adressOut, 17'h0);
        check("async reset dataOut", dataOut, 64'h0);
        check("async reset busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        memValid = 1'b1;
        repeat (3) @(negedge clk);
        memValid = 1'b0;
        check("no writes after reset", write, 1'b0);
        missA = 1'b1;
        adrA  = 19'h00100;
        req_q.push_back(17'h00040);
        @(negedge clk);
        check("post-reset request", {memRequ, memAdr}, {1'b1, 17'h00040});
        missA = 1'b0;
        serve(17'h00040, 0, 0, BL);
        waitIdle();

        repeat (4) @(negedge clk);
        check("all requests seen", req_q.size(), 0);
        check("all writes seen", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
